arm_sequencer: RTL and testbench

//  Sequences the servo PWM generator through the load/deliver cycle.

---
 rtl/arm_sequencer.sv | 163 ++++++++++++++++
 tb/tb_arm_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/arm_sequencer.sv
// Command sequencer for the servo PWM block: runs the automatic load/deliver sequence,
// admits manual UART moves, and flags moves that time out. Optional loop mode: SEQ_LOOP_EN.
module arm_sequencer #(
  parameter int CNT_W          = 26,
  parameter int DWELL_CYCLES   = 13_500_000,
  parameter int TIMEOUT_CYCLES = 54_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] uart_cmd,
  input  logic       uart_cmd_valid,
  input  logic       servo_moving,
  input  logic       servo_reached,
  output logic [2:0] state_desired,
  output logic       cmd_valid,
  output logic       busy,
  output logic [2:0] step_idx,
  output logic       seq_done,
  output logic       uart_drop,
  output logic       fault,
  output logic [2:0] state_dbg
);

`ifdef SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] DWELL_LAST   = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Handshake: cmd_valid is a single-cycle strobe qualifying state_desired; the PWM block
  // has no ready, so a new move is only issued once servo_moving is low.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT     = 3'd2,
    ST_DWELL    = 3'd3,
    ST_MAN_WAIT = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [2:0]       step_n, desired_n;
  logic             cmd_valid_n, seq_done_n, uart_drop_n, fault_n;

  function automatic logic [2:0] step_code(input logic [2:0] idx);
    case (idx)
      3'd0:    step_code = 3'd2;
      3'd1:    step_code = 3'd3;
      3'd2:    step_code = 3'd5;
      3'd3:    step_code = 3'd4;
      default: step_code = 3'd1;
    endcase
  endfunction

  assign cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;
  assign busy      = (state != ST_IDLE) && (state != ST_FAULT);
  assign state_dbg = state;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    step_n      = step_idx;
    desired_n   = state_desired;
    cmd_valid_n = 1'b0;
    seq_done_n  = 1'b0;
    uart_drop_n = uart_cmd_valid && (state != ST_IDLE);
    fault_n     = fault;
    if (abort) begin
      state_n = ST_IDLE;
      step_n  = 3'd0;
      fault_n = 1'b0;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_n     = ST_ISSUE;
            step_n      = 3'd0;
            uart_drop_n = uart_cmd_valid;
          end else if (uart_cmd_valid) begin
            if (uart_cmd != 3'd0 && !servo_moving) begin
              desired_n   = uart_cmd;
              cmd_valid_n = 1'b1;
              cnt_n       = '0;
              state_n     = ST_MAN_WAIT;
            end else begin
              uart_drop_n = 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (!servo_moving) begin
            desired_n   = step_code(step_idx);
            cmd_valid_n = 1'b1;
            cnt_n       = '0;
            state_n     = ST_WAIT;
          end
        end
        ST_WAIT, ST_MAN_WAIT: begin
          // A reply arriving in the timeout cycle still counts as success.
          if (servo_reached) begin
            cnt_n = '0;
            if (state == ST_MAN_WAIT) begin
              state_n = ST_IDLE;
            end else if (step_idx < 3'd4 || (LOOP_EN && start)) begin
              state_n = ST_DWELL;
            end else begin
              seq_done_n = 1'b1;
              step_n     = 3'd0;
              state_n    = ST_IDLE;
            end
          end else if (cnt == TIMEOUT_LAST) begin
            fault_n = 1'b1;
            step_n  = 3'd0;
            state_n = ST_FAULT;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        ST_DWELL: begin
          if (cnt == DWELL_LAST) begin
            cnt_n   = '0;
            step_n  = (step_idx == 3'd4) ? 3'd0 : step_idx + 3'd1;
            state_n = ST_ISSUE;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        ST_FAULT: ;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      step_idx      <= 3'd0;
      state_desired <= 3'd1;
      cmd_valid     <= 1'b0;
      seq_done      <= 1'b0;
      uart_drop     <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      step_idx      <= step_n;
      state_desired <= desired_n;
      cmd_valid     <= cmd_valid_n;
      seq_done      <= seq_done_n;
      uart_drop     <= uart_drop_n;
      fault         <= fault_n;
    end
  end

endmodule

// File: tb/tb_arm_sequencer.sv
// Bench for arm_sequencer: servo reply model, expected-command queue and event counters.
// Loop-mode scenario builds only with SEQ_LOOP_EN defined.
module tb_arm_sequencer;
  localparam int DWELL   = 8;
  localparam int TIMEOUT = 32;
  localparam int REPLY   = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0;
  logic [2:0] uart_cmd = 3'd0;
  logic       uart_cmd_valid = 1'b0;
  logic       servo_moving = 1'b0, servo_reached = 1'b0;
  logic [2:0] state_desired, step_idx, state_dbg;
  logic       cmd_valid, busy, seq_done, uart_drop, fault;

  arm_sequencer #(.CNT_W(26), .DWELL_CYCLES(DWELL), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .uart_cmd(uart_cmd), .uart_cmd_valid(uart_cmd_valid),
    .servo_moving(servo_moving), .servo_reached(servo_reached),
    .state_desired(state_desired), .cmd_valid(cmd_valid), .busy(busy),
    .step_idx(step_idx), .seq_done(seq_done), .uart_drop(uart_drop),
    .fault(fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // scoreboard state
  logic [2:0] exp_q[$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, n_cv = 0, n_done = 0, n_drop = 0;
  int last_cv_cyc = 0, rch_cyc = 0, cd = 0;
  bit prev_cv = 0, gap_armed = 0, reply_en = 1, force_moving = 0, auto_mode = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: sample outputs after the edge, score commands, advance the servo model.
  task automatic tick();
    logic [2:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (cmd_valid) begin
      chk("cv_back_to_back", 32'(prev_cv), 0);
      chk("cmd_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cmd_code", 32'(state_desired), 32'(e));
      end
      if (gap_armed) chk("dwell_gap", cyc - rch_cyc, DWELL + 1);
      gap_armed = 0;
      last_cv_cyc = cyc;
      n_cv++;
    end
    if (seq_done) n_done++;
    if (uart_drop) n_drop++;
    servo_reached = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        servo_reached = 1'b1;
        rch_cyc = cyc + 1;
        gap_armed = auto_mode && (exp_q.size() > 0);
      end
    end
    if (cmd_valid && reply_en) cd = REPLY;
    servo_moving = (cd > 0) || force_moving;
    prev_cv = cmd_valid;
  endtask

  task automatic push_seq();
    exp_q.push_back(3'd2); exp_q.push_back(3'd3); exp_q.push_back(3'd5);
    exp_q.push_back(3'd4); exp_q.push_back(3'd1);
  endtask

  task automatic wait_done(input int target, input string tag);
    int g = 0;
    while (n_done < target && g < 500) begin tick(); g++; end
    chk(tag, 32'(n_done >= target), 1);
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(1, 6)) tick();
  endtask

  initial begin
    int c, d0, dr0, cv0, g, fcyc;
    logic [2:0] code;

    // reset
    #13;
    chk("rst_desired", 32'(state_desired), 1);
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_step", 32'(step_idx), 0);
    chk("rst_flags", {29'd0, seq_done, uart_drop, fault}, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    tick();

    // 1: full auto sequence from a one-cycle start
    auto_mode = 1; push_seq();
    start = 1'b1; c = cyc; tick(); start = 1'b0; tick();
    chk("start_latency", last_cv_cyc - c, 2);
    wait_done(1, "seq1_done");
    tick();
    chk("seq1_done_once", n_done, 1);
    chk("seq1_busy_after", 32'(busy), 0);
    chk("seq1_q_empty", exp_q.size(), 0);
    chk("seq1_step_after", 32'(step_idx), 0);
    idle_gap();

    // 2: manual moves with random codes
    auto_mode = 0;
    for (int i = 0; i < 4; i++) begin
      code = 3'($urandom_range(1, 7));
      exp_q.push_back(code);
      d0 = n_done; dr0 = n_drop;
      uart_cmd = code; uart_cmd_valid = 1'b1; tick(); uart_cmd_valid = 1'b0;
      chk("man_busy", 32'(busy), 1);
      g = 0;
      while (busy && g < 60) begin tick(); g++; end
      chk("man_busy_release", 32'(busy), 0);
      chk("man_no_seq_done", n_done, d0);
      chk("man_no_drop", n_drop, dr0);
      idle_gap();
    end
    // manual code 0, and a manual move while the servo is still moving, are both dropped
    dr0 = n_drop; cv0 = n_cv;
    uart_cmd = 3'd0; uart_cmd_valid = 1'b1; tick(); uart_cmd_valid = 1'b0; tick();
    force_moving = 1; servo_moving = 1'b1;
    uart_cmd = 3'd6; uart_cmd_valid = 1'b1; tick(); uart_cmd_valid = 1'b0; tick();
    force_moving = 0; servo_moving = (cd > 0);
    tick();
    chk("man_drops", n_drop, dr0 + 2);
    chk("man_drop_no_cmd", n_cv, cv0);

    // 3: UART pulse during step 2 is dropped, sequence unchanged
    auto_mode = 1; push_seq(); d0 = n_done; dr0 = n_drop;
    start = 1'b1; tick(); start = 1'b0;
    g = 0;
    while (step_idx != 3'd2 && g < 200) begin tick(); g++; end
    chk("reach_step2", 32'(step_idx), 2);
    repeat ($urandom_range(0, 4)) tick();
    uart_cmd = 3'($urandom_range(1, 7)); uart_cmd_valid = 1'b1; tick(); uart_cmd_valid = 1'b0;
    tick();
    chk("busy_drop", n_drop, dr0 + 1);
    wait_done(d0 + 1, "seq3_done");
    chk("seq3_q_empty", exp_q.size(), 0);
    idle_gap();

    // abort mid-sequence: no seq_done, back to idle, remaining codes never issued
    push_seq(); d0 = n_done;
    start = 1'b1; tick(); start = 1'b0;
    repeat ($urandom_range(5, 60)) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    exp_q.delete(); gap_armed = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_step", 32'(step_idx), 0);
    repeat (DWELL + 4) tick();
    chk("abort_no_done", n_done, d0);
    g = 0;
    while (cd > 0 && g < 20) begin tick(); g++; end
    idle_gap();

    // 4: servo never replies -> timeout fault, start ignored, abort clears
    reply_en = 0; exp_q.push_back(3'd2);
    start = 1'b1; tick(); start = 1'b0;
    g = 0;
    while (!fault && g < 100) begin tick(); g++; end
    fcyc = cyc;
    chk("fault_set", 32'(fault), 1);
    chk("fault_time", fcyc - last_cv_cyc, TIMEOUT);
    chk("fault_not_busy", 32'(busy), 0);
    cv0 = n_cv;
    start = 1'b1; repeat (4) tick(); start = 1'b0; tick();
    chk("fault_sticky", 32'(fault), 1);
    chk("fault_start_ignored", n_cv, cv0);
    abort = 1'b1; tick(); abort = 1'b0; tick();
    chk("abort_clears_fault", 32'(fault), 0);
    chk("abort_idle", 32'(busy), 0);
    reply_en = 1;
    idle_gap();

    // 5: servo still moving at start; start and UART together -> start wins, UART dropped
    force_moving = 1; servo_moving = 1'b1; d0 = n_done; dr0 = n_drop;
    start = 1'b1; uart_cmd = 3'd5; uart_cmd_valid = 1'b1; tick();
    start = 1'b0; uart_cmd_valid = 1'b0;
    repeat ($urandom_range(3, 10)) tick();
    chk("hold_busy", 32'(busy), 1);
    chk("start_uart_drop", n_drop, dr0 + 1);
    push_seq();
    force_moving = 0; servo_moving = (cd > 0); c = cyc;
    tick();
    chk("release_latency", last_cv_cyc - c, 1);
    wait_done(d0 + 1, "seq5_done");
    chk("seq5_q_empty", exp_q.size(), 0);
    idle_gap();

`ifdef SEQ_LOOP_EN
    // 6: start held repeats the sequence with no seq_done until released
    push_seq(); push_seq(); d0 = n_done; cv0 = n_cv;
    start = 1'b1;
    g = 0;
    while (n_cv < cv0 + 6 && g < 600) begin tick(); g++; end
    start = 1'b0;
    chk("loop_cmds", n_cv - cv0, 6);
    chk("loop_no_done", n_done, d0);
    wait_done(d0 + 1, "loop_done");
    chk("loop_q_empty", exp_q.size(), 0);
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
